// File: rtl/flash_texture_fetcher.sv
// rtl/flash_texture_fetcher.sv - fetches a width x height texel block from flash into a valid/ready texel stream
module flash_texture_fetcher #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_master_clk,
    input  logic        i_reset,
    input  logic [31:0] i_cmd_base_address,
    input  logic [7:0]  i_cmd_width,
    input  logic [5:0]  i_cmd_height,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    output logic [31:0] o_flash_read_address,
    output logic        o_flash_read_request,
    input  logic [15:0] i_flash_read_data,
    input  logic        i_flash_read_data_valid,
    output logic [15:0] o_texel_data,
    output logic        o_texel_valid,
    input  logic        i_texel_ready,
    output logic        o_texel_last_in_row,
    output logic        o_texel_last,
    output logic        o_busy,
    output logic        o_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t         r_state;
    logic [31:0]    r_base;
    logic [7:0]     r_width;
    logic [5:0]     r_height;
    logic [7:0]     r_x;
    logic [5:0]     r_y;
    logic [7:0]     r_rx;
    logic [5:0]     r_ry;
    logic [CW-1:0]  r_in_flight;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [15:0]    r_mem      [FIFO_DEPTH];
    logic           r_mem_row  [FIFO_DEPTH];
    logic           r_mem_last [FIFO_DEPTH];
    logic           r_req;
    logic [31:0]    r_addr;
    logic           r_done;

    logic           w_credit;
    logic           w_issue;
    logic           w_ret;
    logic           w_pop;
    logic           w_x_end;
    logic           w_y_end;
    logic           w_rx_end;
    logic           w_ry_end;
    logic [31:0]    w_addr;

    // Credit covers both words already buffered and words still owed by flash.
    assign w_credit = ({1'b0, r_count} + {1'b0, r_in_flight}) < (CW+1)'(FIFO_DEPTH);
    assign w_issue  = (r_state == S_FETCH) && w_credit;
    assign w_ret    = i_flash_read_data_valid && (r_in_flight != '0);
    assign w_pop    = o_texel_valid && i_texel_ready;
    assign w_x_end  = (r_x == r_width - 8'd1);
    assign w_y_end  = (r_y == r_height - 6'd1);
    assign w_rx_end = (r_rx == r_width - 8'd1);
    assign w_ry_end = (r_ry == r_height - 6'd1);
    assign w_addr   = r_base + {18'd0, r_y, 8'd0} + {24'd0, r_x};

    assign o_cmd_ready          = (r_state == S_IDLE);
    assign o_busy               = (r_state != S_IDLE);
    assign o_done               = r_done;
    assign o_flash_read_request = r_req;
    assign o_flash_read_address = r_addr;
    assign o_texel_valid        = (r_count != '0);
    assign o_texel_data         = r_mem[r_rptr];
    assign o_texel_last_in_row  = o_texel_valid && r_mem_row[r_rptr];
    assign o_texel_last         = o_texel_valid && r_mem_last[r_rptr];

    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_rx        <= '0;
            r_ry        <= '0;
            r_in_flight <= '0;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_done      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i]      <= '0;
                r_mem_row[i]  <= 1'b0;
                r_mem_last[i] <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
            r_req  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_base   <= i_cmd_base_address;
                        r_width  <= i_cmd_width;
                        r_height <= i_cmd_height;
                        r_x      <= '0;
                        r_y      <= '0;
                        r_rx     <= '0;
                        r_ry     <= '0;
                        if (i_cmd_width == 8'd0 || i_cmd_height == 6'd0)
                            r_done <= 1'b1;
                        else
                            r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_credit) begin
                        r_req  <= 1'b1;
                        r_addr <= w_addr;
                        if (w_x_end) begin
                            r_x <= '0;
                            r_y <= r_y + 6'd1;
                            if (w_y_end)
                                r_state <= S_DRAIN;
                        end else begin
                            r_x <= r_x + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_in_flight == '0 && r_count == '0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            case ({w_issue, w_ret})
                2'b10:   r_in_flight <= r_in_flight + CW'(1);
                2'b01:   r_in_flight <= r_in_flight - CW'(1);
                default: r_in_flight <= r_in_flight;
            endcase

            // Returns arrive in issue order, so a second raster counter tags each word.
            if (w_ret) begin
                r_mem[r_wptr]      <= i_flash_read_data;
                r_mem_row[r_wptr]  <= w_rx_end;
                r_mem_last[r_wptr] <= w_rx_end && w_ry_end;
                r_wptr             <= r_wptr + AW'(1);
                if (w_rx_end) begin
                    r_rx <= '0;
                    r_ry <= r_ry + 6'd1;
                end else begin
                    r_rx <= r_rx + 8'd1;
                end
            end
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);

            case ({w_ret, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
